// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
//
// Execute stage of the five-stage LA32R pipeline. Sits between the ID stage
// and MEM_stage.
//   - Latches decoded operands under the valid / allow_in handshake.
//   - Evaluates single-cycle ALU operations.
//   - Runs DIV/MOD/DIVU/MODU on a 32-iteration restoring divider, which
//     stalls the stage until the result is final.
//   - Builds the aligned data-SRAM store request.
//
// Ports
//   clk                 pipeline clock
//   reset               asynchronous, active-low reset
//   ds_to_es_valid      ID stage holds a valid instruction
//   es_allow_in         stage can accept a new instruction this cycle
//   ds_pc               PC of the incoming instruction
//   ds_alu_op           operation code (0..11 ALU, 12..15 divide family)
//   ds_src1, ds_src2    operands
//   ds_st_size          store size: 00 none, 01 byte, 10 half, 11 word
//   ds_st_data          store data (rd value)
//   ds_rf_we            instruction writes the register file
//   ds_rf_waddr         destination register
//   ms_allow_in         MEM stage can accept
//   es_to_ms_valid      es_valid && es_ready_go
//   es_valid            stage holds a valid instruction
//   es_ready_go         result is final
//   es_pc               PC of the held instruction
//   es_result           ALU or divider result
//   es_data_sram_we     byte enables of the store request
//   es_data_sram_addr   src1 + src2
//   es_data_sram_wdata  store data replicated across the lanes
//   es_rf_we            {4{rf_we & es_valid}}
//   es_rf_waddr         destination register
//   es_div_busy         divider is iterating
// -----------------------------------------------------------------------------
module exe_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_to_es_valid,
    output logic        es_allow_in,
    input  logic [31:0] ds_pc,
    input  logic [3:0]  ds_alu_op,
    input  logic [31:0] ds_src1,
    input  logic [31:0] ds_src2,
    input  logic [1:0]  ds_st_size,
    input  logic [31:0] ds_st_data,
    input  logic        ds_rf_we,
    input  logic [4:0]  ds_rf_waddr,
    input  logic        ms_allow_in,
    output logic        es_to_ms_valid,
    output logic        es_valid,
    output logic        es_ready_go,
    output logic [31:0] es_pc,
    output logic [31:0] es_result,
    output logic [3:0]  es_data_sram_we,
    output logic [31:0] es_data_sram_addr,
    output logic [31:0] es_data_sram_wdata,
    output logic [3:0]  es_rf_we,
    output logic [4:0]  es_rf_waddr,
    output logic        es_div_busy
);

    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    localparam logic [1:0] ST_BYTE = 2'b01;
    localparam logic [1:0] ST_HALF = 2'b10;
    localparam logic [1:0] ST_WORD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // Two's-complement negate when neg is set. Used both to take operand
    // magnitudes and to restore result signs.
    function automatic logic [DATA_W-1:0] f_cond_neg(input logic neg,
                                                     input logic [DATA_W-1:0] v);
        f_cond_neg = neg ? (~v + 1'b1) : v;
    endfunction

    // -------------------------------------------------------------------------
    // Stage-input registers
    // -------------------------------------------------------------------------
    logic              r_valid;
    logic [31:0]       r_pc;
    logic [3:0]        r_alu_op;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [1:0]        r_st_size;
    logic [DATA_W-1:0] r_st_data;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;

    logic w_latch;
    logic w_ds_is_div;
    logic w_es_is_div;
    logic w_handoff;

    assign w_latch     = es_allow_in && ds_to_es_valid;
    assign w_ds_is_div = (ds_alu_op[3:2] == 2'b11);
    assign w_es_is_div = (r_alu_op[3:2] == 2'b11);
    assign w_handoff   = es_ready_go && ms_allow_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_pc       <= RESET_PC;
            r_alu_op   <= OP_ADD;
            r_src1     <= '0;
            r_src2     <= '0;
            r_st_size  <= 2'b00;
            r_st_data  <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
        end else begin
            if (es_allow_in) begin
                r_valid <= ds_to_es_valid;
            end
            if (w_latch) begin
                r_pc       <= ds_pc;
                r_alu_op   <= ds_alu_op;
                r_src1     <= ds_src1;
                r_src2     <= ds_src2;
                r_st_size  <= ds_st_size;
                r_st_data  <= ds_st_data;
                r_rf_we    <= ds_rf_we;
                r_rf_waddr <= ds_rf_waddr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Divider control FSM
    // -------------------------------------------------------------------------
    div_state_t r_state;
    div_state_t w_state_nxt;
    logic [4:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch && w_ds_is_div) begin
                r_cnt <= 5'd0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // A new divide latched on the handoff edge goes straight back to RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_latch && w_ds_is_div) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 5'd31) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_latch && w_ds_is_div) begin
                    w_state_nxt = S_RUN;
                end else if (w_handoff) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Divider datapath (restoring, one quotient bit per cycle)
    // -------------------------------------------------------------------------
    // r_quot starts as the dividend magnitude; each step shifts its MSB into
    // the partial remainder and shifts the new quotient bit in at the LSB.
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvs;
    logic              r_q_neg;
    logic              r_r_neg;

    logic              w_ds_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W+1:0] w_trial;
    logic              w_trial_ok;

    assign w_ds_signed = !ds_alu_op[1];
    assign w_a_neg     = w_ds_signed && ds_src1[DATA_W-1];
    assign w_b_neg     = w_ds_signed && ds_src2[DATA_W-1];

    // Shifted remainder can reach 33 bits; one more bit keeps the borrow.
    assign w_rem_sh   = {r_rem, r_quot[DATA_W-1]};
    assign w_trial    = {1'b0, w_rem_sh} - {2'b00, r_dvs};
    assign w_trial_ok = !w_trial[DATA_W+1];

    always_ff @(posedge clk) begin
        if (w_latch && w_ds_is_div) begin
            r_quot  <= f_cond_neg(w_a_neg, ds_src1);
            r_dvs   <= f_cond_neg(w_b_neg, ds_src2);
            r_rem   <= '0;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
        end else if (r_state == S_RUN) begin
            r_rem  <= w_trial_ok ? w_trial[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
            r_quot <= {r_quot[DATA_W-2:0], w_trial_ok};
        end
    end

    // Dividing by zero needs no special case: every trial subtract succeeds,
    // giving an all-ones quotient and the dividend as remainder.
    logic [DATA_W-1:0] w_div_result;

    assign w_div_result = r_alu_op[0] ? f_cond_neg(r_r_neg, r_rem)
                                      : f_cond_neg(r_q_neg, r_quot);

    // -------------------------------------------------------------------------
    // Single-cycle ALU
    // -------------------------------------------------------------------------
    logic signed [DATA_W-1:0] w_src1_s;
    logic signed [DATA_W-1:0] w_src2_s;
    logic        [4:0]        w_sa;
    logic        [DATA_W-1:0] w_alu_result;

    assign w_src1_s = r_src1;
    assign w_src2_s = r_src2;
    assign w_sa     = r_src2[4:0];

    always_comb begin
        w_alu_result = '0;
        case (r_alu_op)
            OP_ADD:  w_alu_result = r_src1 + r_src2;
            OP_SUB:  w_alu_result = r_src1 - r_src2;
            OP_SLT:  w_alu_result = {31'd0, (w_src1_s < w_src2_s)};
            OP_SLTU: w_alu_result = {31'd0, (r_src1 < r_src2)};
            OP_AND:  w_alu_result = r_src1 & r_src2;
            OP_OR:   w_alu_result = r_src1 | r_src2;
            OP_NOR:  w_alu_result = ~(r_src1 | r_src2);
            OP_XOR:  w_alu_result = r_src1 ^ r_src2;
            OP_SLL:  w_alu_result = r_src1 << w_sa;
            OP_SRL:  w_alu_result = r_src1 >> w_sa;
            OP_SRA:  w_alu_result = w_src1_s >>> w_sa;
            OP_LUI:  w_alu_result = r_src2;
            default: w_alu_result = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Store request
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] w_addr;
    logic [3:0]        w_we;
    logic [DATA_W-1:0] w_wdata;

    assign w_addr = r_src1 + r_src2;

    always_comb begin
        w_we    = 4'b0000;
        w_wdata = r_st_data;
        case (r_st_size)
            ST_BYTE: begin
                w_we    = 4'b0001 << w_addr[1:0];
                w_wdata = {4{r_st_data[7:0]}};
            end
            ST_HALF: begin
                w_we    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_st_data[15:0]}};
            end
            ST_WORD: begin
                w_we    = 4'b1111;
                w_wdata = r_st_data;
            end
            default: begin
                w_we    = 4'b0000;
                w_wdata = r_st_data;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign es_ready_go        = !w_es_is_div || (r_state == S_DONE);
    assign es_allow_in        = !r_valid || (es_ready_go && ms_allow_in);
    assign es_to_ms_valid     = r_valid && es_ready_go;
    assign es_valid           = r_valid;
    assign es_pc              = r_pc;
    assign es_result          = w_es_is_div ? w_div_result : w_alu_result;
    assign es_data_sram_we    = r_valid ? w_we : 4'b0000;
    assign es_data_sram_addr  = w_addr;
    assign es_data_sram_wdata = w_wdata;
    assign es_rf_we           = {4{r_rf_we & r_valid}};
    assign es_rf_waddr        = r_rf_waddr;
    assign es_div_busy        = (r_state == S_RUN);

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
//
// Directed testbench for exe_stage. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge, half a cycle away from the active
// rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_exe_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic        ds_to_es_valid;
    logic        es_allow_in;
    logic [31:0] ds_pc;
    logic [3:0]  ds_alu_op;
    logic [31:0] ds_src1;
    logic [31:0] ds_src2;
    logic [1:0]  ds_st_size;
    logic [31:0] ds_st_data;
    logic        ds_rf_we;
    logic [4:0]  ds_rf_waddr;
    logic        ms_allow_in;
    logic        es_to_ms_valid;
    logic        es_valid;
    logic        es_ready_go;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [3:0]  es_data_sram_we;
    logic [31:0] es_data_sram_addr;
    logic [31:0] es_data_sram_wdata;
    logic [3:0]  es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic        es_div_busy;

    int n_checks = 0;
    int n_errors = 0;

    exe_stage #(.RESET_PC(RESET_PC)) dut (
        .clk                (clk),
        .reset              (reset),
        .ds_to_es_valid     (ds_to_es_valid),
        .es_allow_in        (es_allow_in),
        .ds_pc              (ds_pc),
        .ds_alu_op          (ds_alu_op),
        .ds_src1            (ds_src1),
        .ds_src2            (ds_src2),
        .ds_st_size         (ds_st_size),
        .ds_st_data         (ds_st_data),
        .ds_rf_we           (ds_rf_we),
        .ds_rf_waddr        (ds_rf_waddr),
        .ms_allow_in        (ms_allow_in),
        .es_to_ms_valid     (es_to_ms_valid),
        .es_valid           (es_valid),
        .es_ready_go        (es_ready_go),
        .es_pc              (es_pc),
        .es_result          (es_result),
        .es_data_sram_we    (es_data_sram_we),
        .es_data_sram_addr  (es_data_sram_addr),
        .es_data_sram_wdata (es_data_sram_wdata),
        .es_rf_we           (es_rf_we),
        .es_rf_waddr        (es_rf_waddr),
        .es_div_busy        (es_div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] pc,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [1:0] sz, input logic [31:0] sd,
                         input logic we, input logic [4:0] wa);
        ds_alu_op      = op;
        ds_pc          = pc;
        ds_src1        = s1;
        ds_src2        = s2;
        ds_st_size     = sz;
        ds_st_data     = sd;
        ds_rf_we       = we;
        ds_rf_waddr    = wa;
        ds_to_es_valid = 1'b1;
    endtask

    // Issue a divide (stage must be able to accept at the next rising edge),
    // count cycles with es_ready_go low and check the final result.
    task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int n;
        drive(op, pc, a, b, 2'b00, 32'd0, 1'b1, 5'd9);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        check({tag, "_busy"}, 32'(es_div_busy), 32'd1);
        n = 0;
        while (!es_ready_go && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_cycles"}, 32'(n), 32'd32);
        check({tag, "_result"}, es_result, exp);
        check({tag, "_to_ms"}, 32'(es_to_ms_valid), 32'd1);
        check({tag, "_pc"}, es_pc, pc);
    endtask

    logic [3:0]  v_op [11];
    logic [31:0] v_a  [11];
    logic [31:0] v_b  [11];
    logic [31:0] v_r  [11];

    initial begin
        int n;
        int n_out;

        v_op = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        v_a  = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0,
                 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1, 32'h80000000, 32'h80000000, 32'hDEADBEEF};
        v_b  = '{32'd5, 32'd1, 32'd1, 32'hFF00FF00, 32'hFF00FF00,
                 32'hFF00FF00, 32'hFF00FF00, 32'h21, 32'd4, 32'd4, 32'h12345000};
        v_r  = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF000F000, 32'hFFF0FFF0,
                 32'h000F000F, 32'h0FF00FF0, 32'd2, 32'h08000000, 32'hF8000000, 32'h12345000};

        reset          = 1'b0;
        ds_to_es_valid = 1'b0;
        ds_pc          = 32'd0;
        ds_alu_op      = 4'd0;
        ds_src1        = 32'd0;
        ds_src2        = 32'd0;
        ds_st_size     = 2'b00;
        ds_st_data     = 32'd0;
        ds_rf_we       = 1'b0;
        ds_rf_waddr    = 5'd0;
        ms_allow_in    = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid",    32'(es_valid), 32'd0);
        check("rst_pc",       es_pc, RESET_PC);
        check("rst_result",   es_result, 32'd0);
        check("rst_addr",     es_data_sram_addr, 32'd0);
        check("rst_wdata",    es_data_sram_wdata, 32'd0);
        check("rst_waddr",    32'(es_rf_waddr), 32'd0);
        check("rst_ready_go", 32'(es_ready_go), 32'd1);
        check("rst_allow_in", 32'(es_allow_in), 32'd1);
        check("rst_sram_we",  32'(es_data_sram_we), 32'd0);
        check("rst_rf_we",    32'(es_rf_we), 32'd0);
        check("rst_to_ms",    32'(es_to_ms_valid), 32'd0);
        check("rst_busy",     32'(es_div_busy), 32'd0);
        reset = 1'b1;

        // ADD then SW on consecutive cycles
        drive(4'd0, 32'h1c000000, 32'd5, 32'd7, 2'b00, 32'd0, 1'b1, 5'd3);
        @(negedge clk);
        check("add_result", es_result, 32'd12);
        check("add_rf_we",  32'(es_rf_we), 32'hF);
        check("add_waddr",  32'(es_rf_waddr), 32'd3);
        check("add_to_ms",  32'(es_to_ms_valid), 32'd1);
        check("add_sram_we", 32'(es_data_sram_we), 32'd0);
        check("add_pc",     es_pc, 32'h1c000000);
        drive(4'd0, 32'h1c000004, 32'h100, 32'd4, 2'b11, 32'hAABBCCDD, 1'b0, 5'd0);
        @(negedge clk);
        check("sw_addr",  es_data_sram_addr, 32'h104);
        check("sw_we",    32'(es_data_sram_we), 32'hF);
        check("sw_wdata", es_data_sram_wdata, 32'hAABBCCDD);
        check("sw_rf_we", 32'(es_rf_we), 32'd0);
        check("sw_pc",    es_pc, 32'h1c000004);

        // ST.B and ST.H
        drive(4'd0, 32'h1c000008, 32'h100, 32'd3, 2'b01, 32'h12345678, 1'b0, 5'd0);
        @(negedge clk);
        check("stb_we",    32'(es_data_sram_we), 32'h8);
        check("stb_wdata", es_data_sram_wdata, 32'h78787878);
        drive(4'd0, 32'h1c00000c, 32'h100, 32'd2, 2'b10, 32'h12345678, 1'b0, 5'd0);
        @(negedge clk);
        check("sth_we",    32'(es_data_sram_we), 32'hC);
        check("sth_wdata", es_data_sram_wdata, 32'h56785678);

        // Remaining ALU ops, one per cycle
        for (int i = 0; i < 11; i++) begin
            drive(v_op[i], 32'h1c000100 + 32'(i * 4), v_a[i], v_b[i], 2'b00, 32'd0, 1'b1, 5'd1);
            @(negedge clk);
            check($sformatf("alu_op%0d", v_op[i]), es_result, v_r[i]);
        end

        // Bubble
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        check("bubble_valid", 32'(es_valid), 32'd0);
        check("bubble_to_ms", 32'(es_to_ms_valid), 32'd0);
        check("bubble_we",    32'(es_data_sram_we), 32'd0);

        // Divides, issued back to back
        run_div("div_m7_2",   4'd12, 32'h1c000200, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_div("mod_m7_2",   4'd13, 32'h1c000204, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_div("div_7_m2",   4'd12, 32'h1c000208, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
        run_div("mod_7_m2",   4'd13, 32'h1c00020c, 32'd7, 32'hFFFFFFFE, 32'd1);
        run_div("divu_by0",   4'd14, 32'h1c000210, 32'h10, 32'd0, 32'hFFFFFFFF);
        run_div("modu_by0",   4'd15, 32'h1c000214, 32'h10, 32'd0, 32'h10);
        run_div("div_ovf",    4'd12, 32'h1c000218, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_div("mod_ovf",    4'd13, 32'h1c00021c, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        run_div("divu_big",   4'd14, 32'h1c000220, 32'hFFFFFFFF, 32'd3, 32'h55555555);

        // Stall in DONE with a divide queued behind it
        drive(4'd14, 32'h1c000300, 32'd100, 32'd7, 2'b00, 32'd0, 1'b1, 5'd4);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        ms_allow_in    = 1'b0;
        n = 0;
        while (!es_ready_go && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", 32'(n), 32'd32);
        drive(4'd15, 32'h1c000304, 32'd100, 32'd7, 2'b00, 32'd0, 1'b1, 5'd5);
        for (int i = 0; i < 5; i++) begin
            check("stall_result",   es_result, 32'd14);
            check("stall_allow_in", 32'(es_allow_in), 32'd0);
            check("stall_to_ms",    32'(es_to_ms_valid), 32'd1);
            check("stall_pc",       es_pc, 32'h1c000300);
            @(negedge clk);
        end
        ms_allow_in = 1'b1;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        check("b2b_busy",     32'(es_div_busy), 32'd1);
        check("b2b_ready_go", 32'(es_ready_go), 32'd0);
        check("b2b_pc",       es_pc, 32'h1c000304);
        n = 0;
        while (!es_ready_go && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("b2b_cycles", 32'(n), 32'd32);
        check("b2b_result", es_result, 32'd2);

        // Asynchronous reset in the middle of a divide
        drive(4'd12, 32'h1c000400, 32'd1000, 32'd3, 2'b00, 32'd0, 1'b1, 5'd6);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(es_div_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_valid",    32'(es_valid), 32'd0);
        check("arst_busy",     32'(es_div_busy), 32'd0);
        check("arst_ready_go", 32'(es_ready_go), 32'd1);
        check("arst_to_ms",    32'(es_to_ms_valid), 32'd0);
        check("arst_pc",       es_pc, RESET_PC);
        @(negedge clk);
        reset = 1'b1;
        n_out = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (es_to_ms_valid) n_out++;
        end
        check("arst_no_stale", 32'(n_out), 32'd0);
        drive(4'd0, 32'h1c000500, 32'd1, 32'd2, 2'b00, 32'd0, 1'b1, 5'd7);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        check("post_rst_result", es_result, 32'd3);
        check("post_rst_to_ms",  32'(es_to_ms_valid), 32'd1);
        @(negedge clk);
        check("post_rst_idle",   32'(es_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage LA32R pipeline, between the ID stage and `MEM_stage`. It latches decoded operands under the valid/allow_in handshake and computes ALU results in one cycle. Signed and unsigned divide/modulo run on a 32-iteration restoring divider that stalls the stage. It also produces the aligned data-SRAM store request (byte enables, address, replicated write data) that `MEM_stage` passes to memory.

## Interface
Parameters:
- `RESET_PC`, 32'h1c000000: value held in `es_pc` while reset is asserted.

Ports:
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ds_to_es_valid`  in  1  ID stage holds a valid instruction.
- `es_allow_in`  out  1  stage can accept a new instruction this cycle.
- `ds_pc`  in  32  PC of the incoming instruction.
- `ds_alu_op`  in  4  operation: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 NOR, 7 XOR, 8 SLL, 9 SRL, 10 SRA, 11 LUI (pass src2), 12 DIV, 13 MOD, 14 DIVU, 15 MODU.
- `ds_src1`, `ds_src2`  in  32  operands.
- `ds_st_size`  in  2  store size: 00 none, 01 byte, 10 half, 11 word.
- `ds_st_data`  in  32  store data (rd value).
- `ds_rf_we`  in  1  instruction writes the register file.
- `ds_rf_waddr`  in  5  destination register.
- `ms_allow_in`  in  1  MEM stage can accept.
- `es_to_ms_valid`  out  1  `es_valid && es_ready_go`.
- `es_valid`  out  1  stage holds a valid instruction.
- `es_ready_go`  out  1  result is final.
- `es_pc`  out  32  PC of the held instruction.
- `es_result`  out  32  ALU or divider result.
- `es_data_sram_we`  out  4  byte enables.
- `es_data_sram_addr`  out  32  `src1 + src2`.
- `es_data_sram_wdata`  out  32  replicated store data.
- `es_rf_we`  out  4  `{4{rf_we & es_valid}}`.
- `es_rf_waddr`  out  5  destination register.
- `es_div_busy`  out  1  divider state is RUN.

## Operation
- **Input latch.** The stage-input registers load when `es_allow_in && ds_to_es_valid`. `es_valid` loads `ds_to_es_valid` whenever `es_allow_in` is high.
- **Handshake.** `es_allow_in = !es_valid || (es_ready_go && ms_allow_in)`. The stage drops nothing and duplicates nothing.
- **ALU.**
  - Shift amount is `src2[4:0]`.
  - SLT compares signed; SLTU compares unsigned.
  - ADD/SUB wrap modulo 2^32.
- **Store request.**
  - Byte: `we = 4'b0001 << addr[1:0]`, `wdata = {4{st_data[7:0]}}`.
  - Half: `we = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{st_data[15:0]}}`. `addr[0]` is ignored.
  - Word: `we = 4'b1111`, `wdata = st_data`.
  - None: `we = 0`.
  - `es_data_sram_we` is forced to 0 when `!es_valid`.
- **Divider FSM: IDLE → RUN → DONE.**
  - IDLE → RUN on the edge that latches op 12–15. The edge loads magnitudes of the operands (signed ops) or raw operands (unsigned), and clears the 5-bit counter.
  - RUN: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). The edge with counter == 31 goes to DONE.
  - DONE → IDLE on the edge where `es_ready_go && ms_allow_in`.
  - Result sign: quotient sign = `sign(a) ^ sign(b)`; remainder sign = `sign(a)`. Results are negated after DONE is reached.
  - Divide by zero: magnitude quotient 32'hFFFFFFFF, remainder = dividend, then the sign rules apply.
  - `0x80000000 / -1`: quotient 0x80000000, remainder 0.
- `es_ready_go = 1` for non-divide ops. For divide ops it is `state == DONE`.

## Timing
- **Non-divide ops.** Result is valid in the first valid cycle. One cycle per instruction when `ms_allow_in` stays high.
- **Divide ops.**
  - Let cycle E be the first cycle the op is valid in the stage.
  - RUN occupies cycles E..E+31.
  - `es_ready_go` rises in cycle E+32.
  - Earliest handoff is at the end of cycle E+32, for 33 cycles total.
- **Back-pressure.** When `ms_allow_in = 0` in DONE, the state, result and all outputs hold.
- **Back-to-back divides.** The next divide's latch edge is the DONE→IDLE edge. That edge goes directly to RUN (latch has priority).
- **Reset values (reset low, async):**
  - state IDLE, `es_valid` 0, `es_pc` = `RESET_PC`.
  - `es_result`, addr, wdata, and `es_rf_waddr` = 0.
  - `es_ready_go` 1, `es_allow_in` 1, `es_data_sram_we` 0, `es_rf_we` 0.
- **Reset mid-divide.** Reset aborts the divide immediately. After reset release, no stale result is emitted.

## Test plan
- **ADD then SW.** Stimulus: ADD 5+7, then SW with src1=0x100, src2=4, data 0xAABBCCDD; `ms_allow_in = 1`. Required: `es_result` = 12, then addr 0x104, we 4'b1111, wdata 0xAABBCCDD, on consecutive cycles.
- **ST.B and ST.H.** Stimulus: ST.B with addr 0x103, data 0x12345678; then ST.H with addr 0x102. Required: ST.B gives we 4'b1000, wdata 0x78787878. ST.H gives we 4'b1100, wdata 0x56785678.
- **DIV signed.** Stimulus: DIV -7 / 2. Required: `es_ready_go` low for 32 cycles; result 0xFFFFFFFD (-3). MOD on the same operands gives 0xFFFFFFFF (-1).
- **DIVU by zero and overflow.** Stimulus: DIVU 0x10 / 0; DIV 0x80000000 / 0xFFFFFFFF. Required: DIVU gives 0xFFFFFFFF, and MODU on the same operands gives 0x10. DIV gives 0x80000000.
- **Stall in DONE, then back-to-back divide.** Stimulus: hold `ms_allow_in = 0` for 5 cycles while in DONE; a divide is queued behind it. Required: outputs stable during the stall, `es_allow_in` = 0, and the second divide enters RUN on the release edge.
- **Async reset mid-divide.** Stimulus: pull `reset` low at RUN counter 10. Required: `es_valid` 0 and state IDLE without waiting for a clock edge. After release, no `es_to_ms_valid` until a new instruction is accepted.
